// File: rtl/border_pkg.sv
// border_pkg: side codes, side_en bit positions and tile-ROM address helper
package border_pkg;
    localparam logic [1:0] SIDE_TOP    = 2'd0;
    localparam logic [1:0] SIDE_BOTTOM = 2'd1;
    localparam logic [1:0] SIDE_LEFT   = 2'd2;
    localparam logic [1:0] SIDE_RIGHT  = 2'd3;
    localparam int SE_TOP    = 0;
    localparam int SE_BOTTOM = 1;
    localparam int SE_LEFT   = 2;
    localparam int SE_RIGHT  = 3;
    function automatic int tile_addr(input int row, input int col, input int tile);
        return row * tile + col;
    endfunction
endpackage

// File: rtl/mod_tracker.sv
// mod_tracker: registers a coordinate and tracks coord mod TILE incrementally, flagging jumps
module mod_tracker #(
    parameter int W    = 11,
    parameter int TILE = 25,
    parameter int MW   = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [W-1:0]  coord,
    input  logic          hold_eq,
    output logic [W-1:0]  q,
    output logic [MW-1:0] mod,
    output logic          err
);
    logic          step;
    logic          same;
    logic [MW-1:0] mod_n;
    always_comb begin
        step  = coord == W'(q + 1'b1);
        same  = hold_eq && coord == q;
        mod_n = coord == '0 ? '0 :
                step ? (mod == MW'(TILE - 1) ? '0 : mod + 1'b1) :
                same ? mod : '0;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            q   <= '0;
            mod <= '0;
            err <= 1'b0;
        end else begin
            q   <= coord;
            mod <= mod_n;
            err <= coord != '0 && !step && !same;
        end
    end
endmodule

// File: rtl/border_tiler.sv
// border_tiler: classifies pixels into border bands and emits scrolled tile-ROM addresses
module border_tiler
    import border_pkg::*;
#(
    parameter int H_ACTIVE = 800,
    parameter int V_ACTIVE = 600,
    parameter int TILE     = 25,
    parameter int THICK    = 1,
    parameter int X_W      = 11,
    parameter int Y_W      = 10,
    parameter int ADDR_W   = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              active,
    input  logic [X_W-1:0]    p_x,
    input  logic [Y_W-1:0]    p_y,
    input  logic [3:0]        side_en,
    input  logic              scroll_en,
    input  logic [7:0]        scroll_div,
    output logic              enable,
    output logic [ADDR_W-1:0] address,
    output logic [1:0]        side,
    output logic              sync_err
);
    localparam int B  = THICK * TILE;
    localparam int MW = TILE > 1 ? $clog2(TILE) : 1;

    logic [X_W-1:0]    x_a;
    logic [Y_W-1:0]    y_a;
    logic [MW-1:0]     xm, ym, soff, row, col;
    logic [7:0]        fcnt;
    logic              act_a, x_err, y_err;
    logic              top, bottom, left, right, on;
    logic [1:0]        sel;
    logic [ADDR_W-1:0] addr_n;

    function automatic logic [MW-1:0] wrap_add(input logic [MW-1:0] a, input logic [MW-1:0] b);
        logic [MW:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s >= (MW+1)'(TILE) ? MW'(s - (MW+1)'(TILE)) : MW'(s);
    endfunction

    mod_tracker #(.W(X_W), .TILE(TILE), .MW(MW)) u_x (
        .clk(clk), .reset(reset), .coord(p_x), .hold_eq(1'b0), .q(x_a), .mod(xm), .err(x_err)
    );
    mod_tracker #(.W(Y_W), .TILE(TILE), .MW(MW)) u_y (
        .clk(clk), .reset(reset), .coord(p_y), .hold_eq(1'b1), .q(y_a), .mod(ym), .err(y_err)
    );

    // Scroll offset advances alongside the frame-start sample so stage B already sees it.
    always_ff @(posedge clk) begin
        if (reset) begin
            act_a <= 1'b0;
            fcnt  <= '0;
            soff  <= '0;
        end else begin
            act_a <= active;
            if (p_x == '0 && p_y == '0 && scroll_en) begin
                if (fcnt == scroll_div) begin
                    fcnt <= '0;
                    soff <= soff == MW'(TILE - 1) ? '0 : soff + 1'b1;
                end else begin
                    fcnt <= fcnt + 1'b1;
                end
            end
        end
    end

    // Corners go to top/bottom and never fall through to left/right when that side is off.
    always_comb begin
        top    = y_a < Y_W'(B);
        bottom = y_a >= Y_W'(V_ACTIVE - B);
        left   = x_a < X_W'(B);
        right  = x_a >= X_W'(H_ACTIVE - B);
        sel    = top ? SIDE_TOP : bottom ? SIDE_BOTTOM : left ? SIDE_LEFT : SIDE_RIGHT;
        on     = act_a && (top || bottom || left || right) && side_en[sel];
        row    = sel[1] ? wrap_add(ym, soff) : ym;
        col    = sel[1] ? xm : wrap_add(xm, soff);
        addr_n = ADDR_W'(tile_addr(int'(row), int'(col), TILE));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            enable   <= 1'b0;
            address  <= '0;
            side     <= '0;
            sync_err <= 1'b0;
        end else begin
            enable   <= on;
            address  <= on ? addr_n : '0;
            side     <= on ? sel : 2'd0;
            sync_err <= x_err | y_err;
        end
    end
endmodule

// File: tb/tb_border_tiler.sv
// tb_border_tiler: directed checks of band classification, scrolling, discontinuities and reset
module tb_border_tiler;
    logic        clk = 1'b0;
    logic        reset, active, scroll_en, enable, sync_err;
    logic [10:0] p_x;
    logic [9:0]  p_y;
    logic [3:0]  side_en;
    logic [7:0]  scroll_div;
    logic [9:0]  address;
    logic [1:0]  side;
    int          n_cmp = 0;
    int          n_bad = 0;

    border_tiler dut (
        .clk(clk), .reset(reset), .active(active), .p_x(p_x), .p_y(p_y),
        .side_en(side_en), .scroll_en(scroll_en), .scroll_div(scroll_div),
        .enable(enable), .address(address), .side(side), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step(input int x, input int y, input logic a);
        p_x = 11'(x);
        p_y = 10'(y);
        active = a;
        @(posedge clk);
        #1;
    endtask

    // Walk column 0 down to line y, then along line y to column x, keeping counters continuous.
    task automatic go(input int x, input int y);
        for (int yy = 0; yy <= y; yy++) step(0, yy, 1'b1);
        for (int xx = 1; xx <= x; xx++) step(xx, y, 1'b1);
    endtask

    initial begin
        reset = 1'b1; active = 1'b0; p_x = '0; p_y = '0;
        side_en = 4'hF; scroll_en = 1'b0; scroll_div = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_enable", enable, 0);
        chk("rst_address", address, 0);
        chk("rst_side", side, 0);
        chk("rst_sync_err", sync_err, 0);
        reset = 1'b0;

        go(0, 0);     step(1, 0, 1'b1);
        chk("p0_0_en", enable, 1);
        chk("p0_0_side", side, 0);
        chk("p0_0_addr", address, 0);
        go(24, 24);   step(25, 24, 1'b1);
        chk("p24_24_addr", address, 624);
        go(30, 10);   step(31, 10, 1'b1);
        chk("p30_10_addr", address, 255);
        go(10, 40);   step(11, 40, 1'b1);
        chk("p10_40_side", side, 2);
        chk("p10_40_addr", address, 385);
        go(799, 300); step(800, 300, 1'b1);
        chk("p799_300_side", side, 3);
        chk("p799_300_addr", address, 24);
        go(400, 300); step(401, 300, 1'b1);
        chk("p400_300_en", enable, 0);
        go(10, 590);  step(11, 590, 1'b1);
        chk("p10_590_side", side, 1);
        chk("p10_590_addr", address, 385);
        go(29, 10);   step(30, 10, 1'b0); step(31, 10, 1'b1);
        chk("inactive_en", enable, 0);
        chk("inactive_addr", address, 0);

        side_en = 4'b1011;
        go(10, 100);  step(11, 100, 1'b1);
        chk("left_off_en", enable, 0);
        go(10, 10);   step(11, 10, 1'b1);
        chk("corner_top_en", enable, 1);
        chk("corner_top_side", side, 0);
        chk("corner_top_addr", address, 260);
        side_en = 4'b1010;
        go(10, 10);   step(11, 10, 1'b1);
        chk("corner_nofall_en", enable, 0);
        side_en = 4'hF;

        scroll_en = 1'b1;
        repeat (3) step(0, 0, 1'b1);
        scroll_en = 1'b0;
        go(5, 2);     step(6, 2, 1'b1);
        chk("scroll3_top_addr", address, 58);
        go(3, 40);    step(4, 40, 1'b1);
        chk("scroll3_left_addr", address, 453);

        go(300, 12);
        reset = 1'b1;
        step(301, 12, 1'b1);
        chk("midrst_enable", enable, 0);
        chk("midrst_address", address, 0);
        chk("midrst_side", side, 0);
        chk("midrst_sync_err", sync_err, 0);
        reset = 1'b0;
        go(5, 2);     step(6, 2, 1'b1);
        chk("after_rst_soff0_addr", address, 55);
        go(24, 24);   step(25, 24, 1'b1);
        chk("after_rst_p24_24_addr", address, 624);

        scroll_en = 1'b1; scroll_div = 8'd1;
        repeat (47) step(0, 0, 1'b1);
        step(0, 0, 1'b1); step(1, 0, 1'b1);
        chk("soff24_addr", address, 24);
        step(0, 0, 1'b1); step(1, 0, 1'b1);
        chk("soff24_hold_addr", address, 24);
        step(0, 0, 1'b1); step(1, 0, 1'b1);
        chk("soff_wrap_addr", address, 0);
        scroll_en = 1'b0;

        go(100, 10);
        step(300, 10, 1'b1);
        step(301, 10, 1'b1);
        chk("xjump_err", sync_err, 1);
        chk("xjump_addr", address, 250);
        step(302, 10, 1'b1);
        chk("xjump_err_clear", sync_err, 0);
        chk("xjump_next_addr", address, 251);
        go(0, 50);
        step(0, 52, 1'b1);
        step(1, 52, 1'b1);
        chk("yjump_err", sync_err, 1);
        chk("yjump_addr", address, 0);
        step(2, 52, 1'b1);
        chk("yjump_err_clear", sync_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
